// File: rtl/sprite_row_fetcher.sv
// Prefetches one sprite row from ROM into a line buffer when a scanline starts,
// then serves registered, colour-keyed pixels for the current DrawX.
module sprite_row_fetcher #(
    parameter int          SPRITE_W  = 16,
    parameter int          SPRITE_H  = 16,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        flip_h,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    input  logic [9:0]  DrawX,
    output logic        busy,
    output logic        ready,
    output logic        overrun,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb
);

    localparam int CW = $clog2(SPRITE_W);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_READY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [3:0]      r_row;
    logic            r_row_hit;
    logic [9:0]      r_sprite_x;
    logic            r_flip;
    logic            r_overrun;
    logic            r_pixel_on;
    logic [23:0]     r_pixel_rgb;
    logic [23:0]     r_buf [SPRITE_W];

    logic [10:0]     w_row;
    logic            w_row_ok;
    logic            w_accept;
    logic            w_last;
    logic [10:0]     w_dx;
    logic            w_dx_ok;
    logic [CW-1:0]   w_idx;
    logic [23:0]     w_texel;
    logic            w_draw;

    // Row offset is signed: a scanline above the sprite shows up as bit 10 set.
    assign w_row    = {1'b0, line_y} - {1'b0, sprite_y};
    assign w_row_ok = !w_row[10] && (w_row < 11'(SPRITE_H));
    assign w_accept = line_start && ((r_state == S_IDLE) || (r_state == S_READY));
    assign w_last   = (r_col == CW'(SPRITE_W - 1));

    assign rom_addr = (r_state == S_FETCH) ? {r_row, r_col} : 8'h00;
    assign busy     = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign ready    = (r_state == S_READY);
    assign overrun  = r_overrun;
    assign pixel_on = r_pixel_on;
    assign pixel_rgb = r_pixel_rgb;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_READY: begin
                if (line_start) begin
                    w_state_nxt = w_row_ok ? S_FETCH : S_READY;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_FETCH: begin
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: w_state_nxt = S_READY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latching, column counter and overrun pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_col      <= '0;
            r_row      <= 4'h0;
            r_row_hit  <= 1'b0;
            r_sprite_x <= 10'd0;
            r_flip     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= line_start && ((r_state == S_FETCH) || (r_state == S_DRAIN));
            if (w_accept) begin
                r_sprite_x <= sprite_x;
                r_flip     <= flip_h;
                r_row      <= w_row[3:0];
                r_row_hit  <= w_row_ok;
                r_col      <= '0;
            end else if (r_state == S_FETCH) begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffer: ROM data lags its address by one cycle, so it lands in col-1.
    // Contents are left unreset; r_row_hit gates any stale data.
    always_ff @(posedge Clk) begin
        if ((r_state == S_FETCH) && (r_col != '0)) begin
            r_buf[r_col - 1'b1] <= rom_data;
        end else if (r_state == S_DRAIN) begin
            r_buf[SPRITE_W-1] <= rom_data;
        end
    end

    // Pixel lookup: dx outside 0..SPRITE_W-1 (including negative) never draws.
    assign w_dx    = {1'b0, DrawX} - {1'b0, r_sprite_x};
    assign w_dx_ok = (w_dx[10:CW] == '0);
    assign w_idx   = r_flip ? ~w_dx[CW-1:0] : w_dx[CW-1:0];
    assign w_texel = r_buf[w_idx];
    assign w_draw  = (r_state == S_READY) && r_row_hit && w_dx_ok && (w_texel != KEY_COLOR);

    // Registered pixel output
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pixel_on  <= 1'b0;
            r_pixel_rgb <= 24'h000000;
        end else begin
            r_pixel_on  <= w_draw;
            r_pixel_rgb <= w_draw ? w_texel : 24'h000000;
        end
    end

endmodule

// File: doc/sprite_row_fetcher.md
SPRITE_ROW_FETCHER -- requirements
Module: sprite_row_fetcher

Interface
REQ-001 Parameter SPRITE_W, default 16, meaning sprite width in pixels and ROM words per row (fixed power of two).
REQ-002 Parameter SPRITE_H, default 16, meaning sprite height in rows.
REQ-003 Parameter KEY_COLOR, default 24'hFF00FF, meaning the transparent colour; never drawn.
REQ-004 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 line_start  input  1  single-cycle request to prefetch the sprite row for line_y.
REQ-007 line_y  input  10  scanline to be drawn next.
REQ-008 sprite_x  input  10  sprite left edge, screen coordinates.
REQ-009 sprite_y  input  10  sprite top edge, screen coordinates.
REQ-010 flip_h  input  1  1 = mirror the sprite horizontally.
REQ-011 rom_addr  output  8  read address to the sprite ROM, {row[3:0], col[3:0]}.
REQ-012 rom_data  input  24  ROM read data, valid one clock after rom_addr is presented.
REQ-013 DrawX  input  10  current pixel column from the VGA controller.
REQ-014 busy  output  1  high while a row fetch is in progress.
REQ-015 ready  output  1  high when the line buffer holds a completed row.
REQ-016 overrun  output  1  one-cycle pulse when line_start arrives while busy.
REQ-017 pixel_on  output  1  high when pixel_rgb is an opaque sprite pixel for DrawX of the previous cycle.
REQ-018 pixel_rgb  output  24  sprite colour for that pixel; 0 when pixel_on is low.

Function
REQ-019 FSM states IDLE, FETCH, DRAIN, READY; a 16x24 line buffer; a 4-bit column counter.
REQ-020 On line_start in IDLE or READY: latch sprite_x and flip_h, compute row = line_y - sprite_y in 11-bit two's complement, clear ready.
REQ-021 If 0 <= row <= SPRITE_H-1: set row_hit=1, enter FETCH with col=0; otherwise set row_hit=0 and enter READY on the next edge without issuing reads.
REQ-022 In FETCH, rom_addr = {row[3:0], col}; col increments every cycle; after col=15 is issued, enter DRAIN.
REQ-023 rom_data is written to buffer[col-1] one edge after each address; DRAIN captures buffer[15], then enters READY.
REQ-024 Latency: ready asserts 17 rising edges after the edge that sampled line_start (hit case); 1 edge (miss case).
REQ-025 busy = 1 exactly in FETCH and DRAIN; rom_addr = 0 outside FETCH.
REQ-026 line_start during FETCH or DRAIN is ignored (fetch continues unchanged) and overrun pulses high for one cycle.
REQ-027 Pixel path, registered one cycle: dx = DrawX - latched sprite_x (11-bit signed); idx = flip_h ? 15-dx : dx.
REQ-028 pixel_on = ready & row_hit & (0 <= dx <= 15) & (buffer[idx] != KEY_COLOR); pixel_rgb = buffer[idx] when pixel_on, else 0.
REQ-029 sprite_x partially off-screen (dx never reaches some columns) shall not wrap: only DrawX with dx in 0..15 draws.
REQ-030 READY persists until the next line_start; IDLE is left only by line_start.

Reset
REQ-031 Reset asserted (any time, including mid-FETCH) forces IDLE, col=0, row_hit=0, rom_addr=0, busy=0, ready=0, overrun=0, pixel_on=0, pixel_rgb=0 immediately.
REQ-032 Line buffer contents are not reset; row_hit=0 guarantees no stale pixels are drawn.
REQ-033 After Reset deasserts, no ROM reads occur until a line_start is sampled.

Verification
REQ-034 sprite_y=100, line_y=103, line_start pulse -> rom_addr 0x30..0x3F on 16 consecutive cycles, busy 17 cycles, ready at edge 17.
REQ-035 ROM row 3 holds 0x000000..0x00000F, sprite_x=200, flip_h=0, DrawX sweep 195..220 -> pixel_on only for DrawX 200..215, pixel_rgb=0x00000F..., i.e. 0x000000 at 200, 0x00000F at 215.
REQ-036 Same, flip_h=1 -> DrawX 200 yields 0x00000F, DrawX 215 yields 0x000000.
REQ-037 Word 5 = KEY_COLOR, flip_h=0, sprite_x=200 -> pixel_on low only at DrawX 205 within the sprite span.
REQ-038 line_y=99 or 116 with sprite_y=100 -> no ROM addresses issued, ready after 1 edge, pixel_on never asserted.
REQ-039 line_start at fetch cycle 5 -> overrun pulses once, addresses continue to 0x3F; Reset at fetch cycle 8 -> all outputs 0 same cycle, state IDLE.
